// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone SRAM arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
  function automatic int tmr_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/wb_sram_arbiter_if.sv
// wb_sram_arbiter_if: Wishbone classic bus bundle
// master modport: drives cyc/stb/we/sel/adr/dat_w, receives ack/err/dat_r
// slave modport:  the reverse view
interface wb_sram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SELW = DW / 8;
  logic            cyc;
  logic            stb;
  logic            we;
  logic [SELW-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;
  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/wb_arb_rr2.sv
// wb_arb_rr2: combinational two-way round-robin picker
// req[1:0] requests, last = previous winner; valid = any request, winner = granted index
module wb_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  assign valid  = |req;
  assign winner = &req ? ~last : req[1];
endmodule

// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter: round-robin two-master Wishbone arbiter with watchdog abort in front of an SRAM slave
// wb_clk_i/wb_rst_i clock and sync active-high reset; m0/m1 master-facing buses;
// s SRAM-facing bus; timeout_irq one-cycle pulse per watchdog abort
module wb_sram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  wb_sram_arbiter_if.slave        m0,
  wb_sram_arbiter_if.slave        m1,
  wb_sram_arbiter_if.master       s,
  output logic                    timeout_irq
);
  localparam int TW = tmr_w(TIMEOUT_CYC);
  state_t          state;
  logic            owner;
  logic            last;
  logic [TW-1:0]   timer;
  logic            valid;
  logic            winner;
  logic            busy;
  logic            abort;
  logic            o_cyc;
  logic            o_stb;
  logic            o_we;
  logic [DW/8-1:0] o_sel;
  logic [AW-1:0]   o_adr;
  logic [DW-1:0]   o_dat;
  wb_arb_rr2 u_rr (
    .req    ({m1.cyc & m1.stb, m0.cyc & m0.stb}),
    .last   (last),
    .valid  (valid),
    .winner (winner)
  );
  // outputs are forced low while reset is asserted, even before the state register clears
  assign busy  = (state == BUSY) & ~wb_rst_i;
  assign abort = (state == ABORT) & ~wb_rst_i;
  always_comb begin
    o_cyc = owner ? m1.cyc   : m0.cyc;
    o_stb = owner ? m1.stb   : m0.stb;
    o_we  = owner ? m1.we    : m0.we;
    o_sel = owner ? m1.sel   : m0.sel;
    o_adr = owner ? m1.adr   : m0.adr;
    o_dat = owner ? m1.dat_w : m0.dat_w;
  end
  assign s.cyc       = busy & o_cyc;
  assign s.stb       = busy & o_stb;
  assign s.we        = busy & o_we;
  assign s.sel       = busy ? o_sel : '0;
  assign s.adr       = busy ? o_adr : '0;
  assign s.dat_w     = busy ? o_dat : '0;
  assign m0.ack      = busy & ~owner & s.ack;
  assign m1.ack      = busy & owner & s.ack;
  assign m0.err      = abort & ~owner;
  assign m1.err      = abort & owner;
  assign m0.dat_r    = (busy & ~owner) ? s.dat_r : (abort & ~owner) ? DW'(ERR_DATA) : '0;
  assign m1.dat_r    = (busy & owner) ? s.dat_r : (abort & owner) ? DW'(ERR_DATA) : '0;
  assign timeout_irq = abort;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          owner <= winner;
          last  <= winner;
          timer <= '0;
          state <= BUSY;
        end
        BUSY: if (!o_cyc) begin
          timer <= '0;
          state <= IDLE;
        end else if (!o_stb || s.ack) begin
          timer <= '0;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          state <= ABORT;
        end else if (timer != TW'(TIMEOUT_CYC)) begin
          timer <= timer + 1'b1;
        end
        ABORT: begin
          timer <= '0;
          state <= o_cyc ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
